// File: rtl/hex_scan_driver_pkg.sv
// Shared definitions for the four-digit hex scan driver.
// Holds the digit count, the scan FSM state type, the all-anodes-off
// pattern, and helpers for anode selection and leading-zero suppression.
package hex_scan_driver_pkg;

  localparam int NUM_DIG = 4;
  localparam int IDX_W   = $clog2(NUM_DIG);

  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_DIG - 1);
  localparam logic [NUM_DIG-1:0] AN_OFF   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    DEAD
  } state_t;

  // Active-low one-hot anode pattern for the selected digit.
  function automatic logic [NUM_DIG-1:0] an_sel(input logic [IDX_W-1:0] idx);
    logic [NUM_DIG-1:0] pat;
    pat      = AN_OFF;
    pat[idx] = 1'b0;
    return pat;
  endfunction

  // Bit k set when digit k is a leading zero: nibbles k..top all zero.
  // Digit 0 is never suppressed so a zero value still shows one "0".
  function automatic logic [NUM_DIG-1:0] lz_mask(input logic [4*NUM_DIG-1:0] nib,
                                                 input logic                   ena);
    logic [NUM_DIG-1:0] mask;
    logic               zero_above;
    mask       = '0;
    zero_above = ena;
    for (int k = NUM_DIG - 1; k >= 1; k--) begin
      zero_above = zero_above && (nib[4*k +: 4] == 4'h0);
      mask[k]    = zero_above;
    end
    return mask;
  endfunction

endpackage

// File: rtl/hex_scan_driver_scan_timer.sv
// Dwell timer for the scan FSM.
// Counts clk cycles from 0 up to a reloadable terminal value and wraps to 0;
// tc is high during the last cycle of the interval.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (holds count at 0)
//   last       : terminal count (interval length minus one)
//   cnt        : current count
//   tc         : terminal-count strobe
module scan_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] last,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  assign tc = (cnt == last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexes four hex digits onto a single hex-to-7-segment decoder.
// Each digit is shown for SCAN_DIV cycles followed by DEAD_CYC cycles with all
// anodes off. New data is double-buffered and only becomes active at a frame
// boundary (or immediately while idle), so a frame never mixes old and new data.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : scan enable, 0 = display dark
//   upd         : load strobe for hex_in / point_in / le_in
//   hex_in      : four nibbles, [3:0] is digit 0 (rightmost)
//   point_in    : per-digit dot request
//   le_in       : per-digit forced blank
//   lz_sup      : leading-zero suppression enable
//   hex         : code to decoder
//   le          : decoder blank (1 = segments off)
//   point       : decoder dot request (1 = lit)
//   an          : digit anodes, active low
//   upd_ack     : pulse when pending data becomes active
//   frame_done  : pulse on the last dead cycle of digit 3
module hex_scan_driver
  import hex_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int DEAD_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 upd,
  input  logic [4*NUM_DIG-1:0] hex_in,
  input  logic [NUM_DIG-1:0]   point_in,
  input  logic [NUM_DIG-1:0]   le_in,
  input  logic                 lz_sup,
  output logic [3:0]           hex,
  output logic                 le,
  output logic                 point,
  output logic [NUM_DIG-1:0]   an,
  output logic                 upd_ack,
  output logic                 frame_done
);

  localparam int MAX_CYC = (SCAN_DIV > DEAD_CYC) ? SCAN_DIV : DEAD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] DEAD_PRE  = CNT_W'(DEAD_CYC - 2);

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;

  logic [4*NUM_DIG-1:0] act_hex, pend_hex, act_hex_nxt;
  logic [NUM_DIG-1:0]   act_pt, pend_pt, act_pt_nxt;
  logic [NUM_DIG-1:0]   act_le, pend_le, act_le_nxt;
  logic                 pend;
  logic                 commit;

  logic [CNT_W-1:0]     cnt;
  logic                 tc;
  logic                 tmr_clr;

  logic [NUM_DIG-1:0]   sup;
  logic [3:0]           hex_nxt;
  logic                 le_nxt, point_nxt, fd_nxt;
  logic [NUM_DIG-1:0]   an_nxt;

  // The timer is held at zero while idle or disabled so every SHOW/DEAD
  // interval starts from a clean count.
  assign tmr_clr = (state == IDLE) || !en;

  scan_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .last  ((state == SHOW) ? SHOW_LAST : DEAD_LAST),
    .cnt   (cnt),
    .tc    (tc)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    commit    = 1'b0;
    fd_nxt    = 1'b0;

    case (state)
      IDLE: begin
        commit = pend;
        if (en) begin
          state_nxt = SHOW;
        end
      end
      SHOW: begin
        if (tc) begin
          state_nxt = DEAD;
          // A one-cycle dead time makes its first cycle also its last.
          if ((DEAD_CYC == 1) && (idx == LAST_IDX)) begin
            fd_nxt = 1'b1;
          end
        end
      end
      DEAD: begin
        if (tc) begin
          state_nxt = SHOW;
          idx_nxt   = idx + 1'b1;
          if (idx == LAST_IDX) begin
            commit = pend && en;
          end
        end else if ((idx == LAST_IDX) && (cnt == DEAD_PRE)) begin
          fd_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (!en) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      fd_nxt    = 1'b0;
    end

    // Outputs are derived from next-cycle state and data so they are
    // registered on the same edge as the state itself.
    act_hex_nxt = commit ? pend_hex : act_hex;
    act_pt_nxt  = commit ? pend_pt  : act_pt;
    act_le_nxt  = commit ? pend_le  : act_le;
    sup         = lz_mask(act_hex_nxt, lz_sup);

    an_nxt    = AN_OFF;
    le_nxt    = 1'b1;
    point_nxt = 1'b0;
    hex_nxt   = hex;
    if (state_nxt == SHOW) begin
      an_nxt    = an_sel(idx_nxt);
      hex_nxt   = act_hex_nxt[{idx_nxt, 2'b00} +: 4];
      le_nxt    = act_le_nxt[idx_nxt] | sup[idx_nxt];
      // The decoder drives the dot even when blanked, so gate it here.
      point_nxt = act_pt_nxt[idx_nxt] & ~le_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      an         <= AN_OFF;
      le         <= 1'b1;
      point      <= 1'b0;
      hex        <= 4'h0;
      upd_ack    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      an         <= an_nxt;
      le         <= le_nxt;
      point      <= point_nxt;
      hex        <= hex_nxt;
      upd_ack    <= commit;
      frame_done <= fd_nxt;
    end
  end

  // A strobe on a commit cycle wins over clearing pend: the old pending
  // data moves to active while the new data stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= 1'b0;
      pend_hex <= '0;
      pend_pt  <= '0;
      pend_le  <= '0;
      act_hex  <= '0;
      act_pt   <= '0;
      act_le   <= '0;
    end else begin
      if (upd) begin
        pend     <= 1'b1;
        pend_hex <= hex_in;
        pend_pt  <= point_in;
        pend_le  <= le_in;
      end else if (commit) begin
        pend <= 1'b0;
      end
      if (commit) begin
        act_hex <= pend_hex;
        act_pt  <= pend_pt;
        act_le  <= pend_le;
      end
    end
  end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Directed testbench for hex_scan_driver with SCAN_DIV=4, DEAD_CYC=2.
module tb_hex_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        upd = 1'b0;
  logic [15:0] hex_in = '0;
  logic [3:0]  point_in = '0;
  logic [3:0]  le_in = '0;
  logic        lz_sup = 1'b0;
  logic [3:0]  hex;
  logic        le;
  logic        point;
  logic [3:0]  an;
  logic        upd_ack;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  hex_scan_driver #(
    .SCAN_DIV (4),
    .DEAD_CYC (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .upd        (upd),
    .hex_in     (hex_in),
    .point_in   (point_in),
    .le_in      (le_in),
    .lz_sup     (lz_sup),
    .hex        (hex),
    .le         (le),
    .point      (point),
    .an         (an),
    .upd_ack    (upd_ack),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks one full 24-cycle frame starting at digit 0, first SHOW cycle.
  // Up to two load strobes ({le,point,hex}) may be injected at given cycles.
  task automatic run_frame(input string name, input logic [15:0] hx,
                           input logic [3:0] exp_le, input logic [3:0] exp_pt,
                           input bit ack0,
                           input int inj_a, input logic [23:0] dat_a,
                           input int inj_b, input logic [23:0] dat_b);
    int cyc;
    logic [3:0] an_exp;
    cyc = 0;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 6; c++) begin
        if (c < 4) begin
          an_exp    = 4'b1111;
          an_exp[d] = 1'b0;
          chk($sformatf("%s d%0d c%0d an", name, d, c), 32'(an), 32'(an_exp));
          chk($sformatf("%s d%0d c%0d hex", name, d, c), 32'(hex), 32'(hx[4*d +: 4]));
          chk($sformatf("%s d%0d c%0d le", name, d, c), 32'(le), 32'(exp_le[d]));
          chk($sformatf("%s d%0d c%0d point", name, d, c), 32'(point), 32'(exp_pt[d]));
        end else begin
          chk($sformatf("%s d%0d dead%0d an", name, d, c), 32'(an), 32'hF);
          chk($sformatf("%s d%0d dead%0d le", name, d, c), 32'(le), 32'h1);
          chk($sformatf("%s d%0d dead%0d point", name, d, c), 32'(point), 32'h0);
        end
        chk($sformatf("%s cyc%0d upd_ack", name, cyc), 32'(upd_ack), 32'(ack0 && cyc == 0));
        chk($sformatf("%s cyc%0d frame_done", name, cyc), 32'(frame_done), 32'(cyc == 23));
        if (cyc == inj_a) begin
          {le_in, point_in, hex_in} = dat_a;
          upd = 1'b1;
        end
        if (cyc == inj_b) begin
          {le_in, point_in, hex_in} = dat_b;
          upd = 1'b1;
        end
        step();
        upd = 1'b0;
        cyc++;
      end
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) step();
    chk("rst an", 32'(an), 32'hF);
    chk("rst le", 32'(le), 32'h1);
    chk("rst point", 32'(point), 32'h0);
    chk("rst hex", 32'(hex), 32'h0);
    chk("rst upd_ack", 32'(upd_ack), 32'h0);
    chk("rst frame_done", 32'(frame_done), 32'h0);
    rst_n = 1'b1;
    step();

    // Load while idle, then enable
    {le_in, point_in, hex_in} = {4'b0000, 4'b0100, 16'h1A2F};
    upd = 1'b1;
    step();
    upd = 1'b0;
    chk("idle upd_ack pre", 32'(upd_ack), 32'h0);
    chk("idle an", 32'(an), 32'hF);
    step();
    chk("idle upd_ack", 32'(upd_ack), 32'h1);
    chk("idle an after ack", 32'(an), 32'hF);
    chk("idle le", 32'(le), 32'h1);
    en = 1'b1;
    step();

    run_frame("f1", 16'h1A2F, 4'b0000, 4'b0100, 1'b0, -1, '0, -1, '0);
    // BEEF mid-frame, then 0030 on the commit cycle
    run_frame("f2", 16'h1A2F, 4'b0000, 4'b0100, 1'b0,
              6, {4'b0000, 4'b0000, 16'hBEEF}, 23, {4'b0000, 4'b1000, 16'h0030});
    lz_sup = 1'b1;
    run_frame("f3", 16'hBEEF, 4'b0000, 4'b0000, 1'b1, -1, '0, -1, '0);
    run_frame("f4", 16'h0030, 4'b1100, 4'b0000, 1'b1,
              6, {4'b0000, 4'b0001, 16'h0000}, -1, '0);
    run_frame("f5", 16'h0000, 4'b1110, 4'b0001, 1'b1,
              6, {4'b0101, 4'b1111, 16'h5678}, -1, '0);
    run_frame("f6", 16'h5678, 4'b0101, 4'b1010, 1'b1,
              3, {4'b0000, 4'b0000, 16'h1111}, 15, {4'b0000, 4'b0100, 16'h2222});
    run_frame("f7", 16'h2222, 4'b0000, 4'b0100, 1'b1, -1, '0, -1, '0);

    // Drop en during digit 2 SHOW
    repeat (12) step();
    chk("endrop pre an", 32'(an), 32'hB);
    chk("endrop pre point", 32'(point), 32'h1);
    en = 1'b0;
    step();
    chk("endrop an", 32'(an), 32'hF);
    chk("endrop le", 32'(le), 32'h1);
    chk("endrop point", 32'(point), 32'h0);
    step();
    chk("endrop idle an", 32'(an), 32'hF);
    en = 1'b1;
    step();
    run_frame("f8", 16'h2222, 4'b0000, 4'b0100, 1'b0, -1, '0, -1, '0);

    // Async reset mid-SHOW with data pending
    repeat (6) step();
    {le_in, point_in, hex_in} = {4'b0000, 4'b0000, 16'h9999};
    upd = 1'b1;
    step();
    upd = 1'b0;
    chk("arst pre an", 32'(an), 32'hD);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst an", 32'(an), 32'hF);
    chk("arst le", 32'(le), 32'h1);
    chk("arst point", 32'(point), 32'h0);
    chk("arst hex", 32'(hex), 32'h0);
    chk("arst upd_ack", 32'(upd_ack), 32'h0);
    chk("arst frame_done", 32'(frame_done), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    run_frame("f9", 16'h0000, 4'b1110, 4'b0000, 1'b0, -1, '0, -1, '0);
    run_frame("f10", 16'h0000, 4'b1110, 4'b0000, 1'b0, -1, '0, -1, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex_scan_driver.md
Name: hex_scan_driver

Overview:
- Time-multiplexes four hex digits onto one 4-bit hex-to-7-segment decoder and drives the active-low digit anodes.
- Sits directly upstream of the decoder: supplies the 4-bit code (D3..D0), the blank control LE (1 = all segments off) and the decimal-point request (1 = dot lit) for the currently selected digit.
- Adds frame-synchronous double-buffered loading, a dead-time between digits against ghosting, and optional leading-zero suppression.

Parameters:
- SCAN_DIV, 100000, clk cycles each digit is shown (≥2).
- DEAD_CYC, 16, clk cycles with all anodes off between digits (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable; 0 = display dark.
- upd  in  1  single-cycle load strobe for hex_in/point_in/le_in.
- hex_in  in  16  four nibbles; [3:0] is digit 0 (rightmost).
- point_in  in  4  per-digit dot request, bit i for digit i.
- le_in  in  4  per-digit forced blank, bit i for digit i.
- lz_sup  in  1  leading-zero suppression enable (sampled live).
- hex  out  4  code to decoder D3..D0.
- le  out  1  decoder blank; 1 = segments off.
- point  out  1  decoder dot request; 1 = dot lit.
- an  out  4  digit anodes, active low, at most one bit low.
- upd_ack  out  1  one-cycle pulse when pending data becomes active.
- frame_done  out  1  one-cycle pulse at the end of digit 3's dead time.

Behaviour:
- Reset (async, rst_n=0): state IDLE, idx=0, prescaler=0, active and pending registers=0, pend=0; outputs an=4'b1111, le=1, point=0, hex=0, upd_ack=0, frame_done=0.
- All outputs are registered and update on the same edge as the state.
- States:
  - IDLE: an=1111, le=1, point=0. Leave to SHOW(idx 0) the cycle after en=1.
  - SHOW: an[idx]=0, hex=active nibble idx, le and point as computed below. Lasts exactly SCAN_DIV cycles, then DEAD.
  - DEAD: an=1111, le=1, point=0, hex holds. Lasts exactly DEAD_CYC cycles, then idx=(idx+1) mod 4 and SHOW.
- Frame length is 4*(SCAN_DIV+DEAD_CYC) cycles. frame_done pulses on the last DEAD cycle of idx 3.
- en=0 in any state: next cycle IDLE, prescaler cleared, idx=0.
- Blank/point in SHOW:
  - le = active_le[idx] OR suppressed(idx).
  - point = active_point[idx] AND NOT le. The decoder passes the dot regardless of LE, so the dot must be gated here.
- Leading-zero suppression: with lz_sup=1, digit k (k=3..1) is suppressed when active nibbles k..3 are all zero. Digit 0 is never suppressed.
- Loading:
  - upd=1 copies hex_in/point_in/le_in into pending and sets pend. A later upd before commit overwrites pending (last wins).
  - Commit (pending→active, pend cleared, upd_ack=1 for one cycle) happens only on the DEAD(idx 3)→SHOW(idx 0) transition, or on the cycle after upd while in IDLE.
  - This guarantees no frame ever mixes old and new data.
  - upd on a commit cycle: the old pending is committed, the new data becomes pending, pend stays 1.
- Async reset mid-frame: anodes go off immediately, and pending data is discarded.

Decomposition:
- Shared package holds:
  - NUM_DIG=4.
  - State enum {IDLE, SHOW, DEAD}.
  - AN_OFF=4'b1111.
  - Function idx→one-hot active-low anode pattern.
- One sub-module, scan_timer: a counter with a reloadable terminal count (SCAN_DIV or DEAD_CYC) and a synchronous clear. It outputs a terminal-count strobe to the FSM.

Test Plan (SCAN_DIV=4, DEAD_CYC=2):
- Reset then en=1, upd with hex_in=16'h1A2F, point_in=4'b0100, le_in=0 in IDLE:
  - upd_ack pulses, then an=1110/hex=F for 4 cycles, 1111/le=1 for 2 cycles.
  - Then 1101/hex=2, then 1011/hex=A with point=1, then 0111/hex=1. frame_done fires after 24 cycles.
- upd with 16'hBEEF during digit 1 SHOW:
  - Digits 2 and 3 still show A and 1.
  - upd_ack fires on the wrap to digit 0, then F,E,E,B are shown.
- lz_sup=1, hex=16'h0030, point_in=4'b1000:
  - Digits 3 and 2 have le=1 and point=0; digit 1 shows hex=3, digit 0 shows hex=0 with le=0.
  - With hex=16'h0000, only digit 0 is lit.
- Drop en during digit 2 SHOW:
  - Next cycle an=1111, le=1, point=0.
  - Re-assert en: one cycle later an=1110, a full SCAN_DIV for digit 0.
- Two upd strobes (16'h1111, then 16'h2222) within one frame: a single upd_ack, and 2222 is displayed.
- rst_n low mid-SHOW (asynchronous to clk):
  - Outputs go to reset values before the next edge.
  - After release with en=1, scan restarts at digit 0 showing 0.
